// File: rtl/demux_pkg.sv
// Shared types and helpers for the serial-to-parallel demux receiver.
package demux_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    // Lane-select counter width; a single lane still needs one bit.
    function automatic int sel_width(input int ins);
        return (ins <= 1) ? 1 : $clog2(ins);
    endfunction

endpackage

// File: rtl/demux_generic_1bit.sv
// Combinational 1-to-INS decoder: drives d onto lane s and zero onto every other lane.
module demux_generic_1bit
    import demux_pkg::*;
#(
    parameter int INS  = 4,
    parameter int SELW = sel_width(INS)
) (
    input  logic            d,
    input  logic [SELW-1:0] s,
    output logic [INS-1:0]  f
);

    always_comb begin
        f = '0;
        if (int'(s) < INS) begin
            f[s] = d;
        end
    end

endmodule

// File: rtl/demux_deserializer.sv
// Collects a framed 1-bit stream into INS-bit words, LSB first, behind a one-entry output buffer.
module demux_deserializer
    import demux_pkg::*;
#(
    parameter int INS  = 4,
    parameter int SELW = sel_width(INS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_valid,
    input  logic            s_data,
    input  logic            s_start,
    output logic            s_ready,
    output logic [INS-1:0]  m_data,
    output logic            m_valid,
    input  logic            m_ready,
    output logic            frame_err,
    output logic [SELW-1:0] sel
);

    localparam logic [SELW-1:0] LAST_SEL = SELW'(INS - 1);

    state_t         state;
    logic [INS-1:0] lanes;
    logic [INS-1:0] lane_we;
    logic [INS-1:0] next_lanes;
    logic [INS-1:0] start_word;
    logic           accept;

    // Only the completing bit has to wait for the buffered word to drain.
    assign s_ready = !(state == COLLECT && sel == LAST_SEL && m_valid && !m_ready);
    assign accept  = s_valid && s_ready;

    demux_generic_1bit #(.INS(INS), .SELW(SELW)) u_lane_dec (
        .d (1'b1),
        .s (sel),
        .f (lane_we)
    );

    assign next_lanes = (lanes & ~lane_we) | (lane_we & {INS{s_data}});
    assign start_word = {{(INS-1){1'b0}}, s_data};

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            sel       <= '0;
            lanes     <= '0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
            if (accept) begin
                if (s_start) begin
                    // A start always opens a fresh frame; mid-frame it discards the partial word.
                    lanes <= start_word;
                    sel   <= SELW'(1);
                    state <= COLLECT;
                    if (state == COLLECT && sel != '0) begin
                        frame_err <= 1'b1;
                    end
                end else if (state == COLLECT) begin
                    lanes <= next_lanes;
                    if (sel == LAST_SEL) begin
                        m_data  <= next_lanes;
                        m_valid <= 1'b1;
                        sel     <= '0;
                        state   <= IDLE;
                    end else begin
                        sel <= sel + SELW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: doc/demux_deserializer.md
Name: demux_deserializer

Overview:
Serial-to-parallel receiver that routes each incoming bit to one lane of an INS-bit word, selected by an internal counter. It is the demultiplexing counterpart of the team's mux_generic_1bit-based selection logic. A framed 1-bit stream arrives under a valid/ready handshake, and completed words leave on a single-entry buffered valid/ready output. It sits between serial link logic and parallel datapath consumers.

Parameters:
INS, 4, output word width and number of demux lanes (>= 2)
SELW, $clog2(INS), lane-select counter width (derived; do not override)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
s_valid  in  1  serial bit present
s_data  in  1  serial bit
s_start  in  1  qualifies s_data as lane 0 of a new frame
s_ready  out  1  serial bit accepted this cycle when s_valid && s_ready
m_data  out  INS  assembled word; lane k = k-th bit after start (LSB first)
m_valid  out  1  m_data holds a completed word
m_ready  in  1  consumer accepts word when m_valid && m_ready
frame_err  out  1  one-cycle pulse: start seen mid-frame, partial word discarded
sel  out  SELW  current lane index (debug/observe)

Behaviour:
- Reset (reset=1 at posedge): state=IDLE, sel=0, shift/lane register=0, m_data=0, m_valid=0, frame_err=0. Reset overrides all other events in the same cycle, including mid-frame and with m_valid pending; the pending word is lost.
- Accept = s_valid && s_ready.
- States:
  - IDLE: accepted bits with s_start=0 are dropped. An accepted bit with s_start=1 writes lane 0, sets sel=1, and moves to COLLECT.
  - COLLECT: an accepted bit writes lane[sel] and sel increments.
- Start in COLLECT: an accepted bit with s_start=1 while sel!=0 restarts the frame. The bit goes to lane 0, sel=1, state stays COLLECT, and frame_err=1 for exactly that cycle. Lanes 1..INS-1 are cleared.
- Completion: an accepted bit at sel==INS-1 (s_start=0) loads m_data with the full word including this bit, sets m_valid=1, sets sel=0, and returns to IDLE. Word latency: m_valid is high the cycle after the last bit is accepted.
- INS-bit frames are back-to-back only via s_start. A bit without s_start arriving after completion is dropped in IDLE.
- Output buffer: m_valid clears on m_valid && m_ready unless a new word completes in the same cycle. In that case m_data is replaced and m_valid stays 1, with no bubble.
- s_ready = !(state==COLLECT && sel==INS-1 && m_valid && !m_ready). Only the completing bit stalls. Earlier lanes fill while the previous word waits. s_ready is combinational from state, sel, m_valid and m_ready; it does not depend on s_valid.
- m_data is stable while m_valid && !m_ready.
- frame_err is registered, 0 in all other cycles.
- sel is always in range 0..INS-1 and never wraps past INS-1.

Decomposition:
- Package demux_pkg: state enum (IDLE, COLLECT) and a sel_width(INS) function.
- Sub-module demux_generic_1bit #(INS): combinational 1-to-INS decoder. Inputs d and s[SELW-1:0]; output one-hot-qualified f[INS-1:0] with f[s]=d and all others 0. It is the inverse of mux_generic_1bit and is instantiated for the lane write-enable.
- The top level holds the FSM, counter, lane register and output buffer.

Test Plan:
1. INS=4. Reset, then start with bits 1,0,1,1 (lanes 0..3), m_ready=1 -> m_valid=1 one cycle after the 4th bit, m_data=4'b1101, then m_valid=0.
2. Bits 1,1 without s_start in IDLE -> no m_valid and sel stays 0. Then frame 0,1,1,0 -> m_data=4'b0110.
3. Start, bits 1,1, then start with 0 mid-frame -> frame_err pulses once. Continue with 1,0,1 -> m_data=4'b1010.
4. m_ready=0 with first word 4'hA pending; second frame sends 3 bits -> s_ready stays 1 through lane 2. On the 4th bit s_ready=0 until m_ready=1. That cycle: word A accepted, 4th bit accepted, next cycle m_data=second word, m_valid=1.
5. Completion and m_ready coincide (m_valid=1, m_ready=1, last bit accepted) -> m_valid stays 1 and m_data updates with no bubble.
6. Assert reset at sel=2 with m_valid=1 -> next cycle m_valid=0, m_data=0, sel=0, state IDLE, no frame_err.
